// File: rtl/pe_mac_vec_pkg.sv
// pe_pkg: shared FSM state type, accumulator width derivation and saturation helper for pe_mac_vec
package pe_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  function automatic int acc_width(input int data_w, input int l_ram_size);
    return 2 * data_w + l_ram_size;
  endfunction
  // Clamp a sign-extended accumulator into the signed out_w range.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] acc, input int out_w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return acc > hi ? hi : acc < lo ? lo : acc;
  endfunction
endpackage

// File: rtl/pe_mac_vec_if.sv
// pe_mac_vec_if: bundles RAM preload, job control, A stream and result handshake of pe_mac_vec
//   RAM preload : din, addr, we
//   job control : start, len, busy
//   A stream    : ain, ain_valid, ain_ready
//   result      : dout, dvalid, dready
//   master = broadcaster/collector side, slave = PE side
interface pe_mac_vec_if #(parameter int DATA_W = 8, parameter int L_RAM_SIZE = 3, parameter int OUT_W = 16);
  logic [DATA_W-1:0] din;
  logic [L_RAM_SIZE-1:0] addr;
  logic we;
  logic start;
  logic [L_RAM_SIZE:0] len;
  logic busy;
  logic signed [DATA_W-1:0] ain;
  logic ain_valid;
  logic ain_ready;
  logic [OUT_W-1:0] dout;
  logic dvalid;
  logic dready;
  modport master(output din, addr, we, start, len, ain, ain_valid, dready, input busy, ain_ready, dout, dvalid);
  modport slave(input din, addr, we, start, len, ain, ain_valid, dready, output busy, ain_ready, dout, dvalid);
endinterface

// File: rtl/pe_mac_vec_ram.sv
// pe_ram: single-port synchronous RAM, DATA_W x 2**L_RAM_SIZE, registered read, block RAM style
//   clk   : clock
//   en    : port enable (read and/or write)
//   we    : write enable
//   addr  : shared read/write address
//   wdata : write data
//   rdata : read data, one cycle after an enabled access
module pe_ram #(parameter int DATA_W = 8, parameter int L_RAM_SIZE = 3) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [L_RAM_SIZE-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);
  logic [DATA_W-1:0] mem [2**L_RAM_SIZE];
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
    end
  end
endmodule

// File: rtl/pe_mac_vec.sv
// pe_mac_vec: signed dot product of a streamed A vector with a B vector held in local RAM
//   aclk, areset : clock, synchronous active-high reset
//   bus (slave)  : RAM preload din/addr/we, job start/len/busy,
//                  A stream ain/ain_valid/ain_ready, result dout/dvalid/dready
//   PE_MAC_VEC_SAT_EN defined: dout saturates to signed OUT_W; undefined: dout wraps
module pe_mac_vec import pe_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int L_RAM_SIZE = 3,
  parameter int OUT_W = 16,
  localparam int ACC_W = acc_width(DATA_W, L_RAM_SIZE)
) (
  input logic aclk,
  input logic areset,
  pe_mac_vec_if.slave bus
);
  localparam logic [L_RAM_SIZE:0] ONE = 1;
  state_t state;
  logic [L_RAM_SIZE:0] len_q, idx;
  logic signed [DATA_W-1:0] a1;
  logic [DATA_W-1:0] rdata;
  logic signed [2*DATA_W-1:0] p2;
  logic v1, v2, beat;
  logic signed [ACC_W-1:0] acc, acc_next;
  logic [OUT_W-1:0] res;
  assign beat = bus.ain_valid && bus.ain_ready;
  // The final product is folded in on the same edge that enters DONE, so dout
  // is taken from the post-add value to hit the 3-cycle latency.
  assign acc_next = acc + (v2 ? ACC_W'(p2) : '0);
`ifdef PE_MAC_VEC_SAT_EN
  assign res = OUT_W'(sat_signed(64'(acc_next), OUT_W));
`else
  assign res = OUT_W'(64'(acc_next));
`endif
  // Writes own the single port; a beat colliding with a write reads garbage.
  pe_ram #(.DATA_W(DATA_W), .L_RAM_SIZE(L_RAM_SIZE)) u_ram (
    .clk(aclk),
    .en(bus.we || beat),
    .we(bus.we),
    .addr(bus.we ? bus.addr : idx[L_RAM_SIZE-1:0]),
    .wdata(bus.din),
    .rdata(rdata)
  );
  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= S_IDLE;
      len_q <= '0;
      idx <= '0;
      a1 <= '0;
      p2 <= '0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      acc <= '0;
      bus.dout <= '0;
      bus.dvalid <= 1'b0;
      bus.ain_ready <= 1'b0;
      bus.busy <= 1'b0;
    end else begin
      v1 <= beat;
      v2 <= v1;
      if (beat) a1 <= bus.ain;
      if (v1) p2 <= a1 * $signed(rdata);
      acc <= acc_next;
      case (state)
        S_IDLE: if (bus.start && bus.len != '0) begin
          state <= S_RUN;
          len_q <= bus.len;
          idx <= '0;
          acc <= '0;
          bus.ain_ready <= 1'b1;
          bus.busy <= 1'b1;
        end
        S_RUN: if (beat) begin
          idx <= idx + ONE;
          if (idx == len_q - ONE) begin
            state <= S_DRAIN;
            bus.ain_ready <= 1'b0;
          end
        end
        S_DRAIN: if (!v1) begin
          state <= S_DONE;
          bus.dout <= res;
          bus.dvalid <= 1'b1;
        end
        S_DONE: if (bus.dready) begin
          state <= S_IDLE;
          bus.dvalid <= 1'b0;
          bus.busy <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pe_mac_vec.sv
// tb_pe_mac_vec: scoreboard bench for pe_mac_vec with directed and randomized dot-product jobs
module tb_pe_mac_vec;
  localparam int DW = 8, LR = 3, OW = 16, DEPTH = 8;
  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;
  pe_mac_vec_if #(.DATA_W(DW), .L_RAM_SIZE(LR), .OUT_W(OW)) bus();
  pe_mac_vec #(.DATA_W(DW), .L_RAM_SIZE(LR), .OUT_W(OW)) dut (.aclk(aclk), .areset(areset), .bus(bus));
  int compared = 0, mismatched = 0;
  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] mon_e;
  int ram_m[DEPTH];
  task automatic check(input string name, input longint act, input longint req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask
  // Reference: plain sum of products over the model RAM, then wrap or clamp.
  function automatic logic [OW-1:0] model(input int n, input int a[DEPTH]);
    longint s = 0;
    for (int i = 0; i < n; i++) s += longint'(a[i]) * longint'(ram_m[i]);
`ifdef PE_MAC_VEC_SAT_EN
    if (s > (longint'(1) << (OW - 1)) - 1) s = (longint'(1) << (OW - 1)) - 1;
    else if (s < -(longint'(1) << (OW - 1))) s = -(longint'(1) << (OW - 1));
`endif
    return OW'(s);
  endfunction
  always @(negedge aclk) begin
    if (!areset && bus.ain_ready) check("no_ram_write_in_run", bus.we, 0);
    if (!areset && bus.dvalid && bus.dready) begin
      if (exp_q.size() == 0) check("spurious_dvalid", bus.dvalid, 0);
      else begin
        mon_e = exp_q.pop_front();
        check("dout", $signed(bus.dout), $signed(mon_e));
      end
    end
  end
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask
  task automatic wr(input int i, input int v);
    bus.we = 1'b1;
    bus.addr = LR'(i);
    bus.din = DW'(v);
    tick();
    bus.we = 1'b0;
    ram_m[i] = v;
  endtask
  // gap: forced idle cycles before every beat but the first; pct: random bubble chance.
  task automatic run_job(input int n, input int a[DEPTH], input int gap, input int pct);
    int c, lb;
    exp_q.push_back(model(n, a));
    bus.start = 1'b1;
    bus.len = (LR + 1)'(n);
    tick();
    bus.start = 1'b0;
    c = 1;
    lb = 0;
    check("busy_after_start", bus.busy, 1);
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < (i > 0 ? gap : 0); g++) begin bus.ain_valid = 1'b0; tick(); c++; end
      while (pct > 0 && int'($urandom_range(99)) < pct) begin bus.ain_valid = 1'b0; tick(); c++; end
      bus.ain = DW'(a[i]);
      bus.ain_valid = 1'b1;
      check("ain_ready_in_run", bus.ain_ready, 1);
      lb = c;
      tick();
      c++;
    end
    bus.ain_valid = 1'b0;
    check("ain_ready_low_after_last", bus.ain_ready, 0);
    while (!bus.dvalid && c < lb + 20) begin tick(); c++; end
    check("latency_after_last_beat", c - lb, 3);
    if (gap == 0 && pct == 0) check("dvalid_cycle_from_start", c, n + 3);
    if (bus.dready) begin
      tick();
      check("busy_after_accept", bus.busy, 0);
      check("dvalid_after_accept", bus.dvalid, 0);
    end
  endtask
  initial begin
    int a[DEPTH];
    int n;
    bus.we = 0; bus.addr = '0; bus.din = '0; bus.start = 0; bus.len = '0;
    bus.ain = '0; bus.ain_valid = 0; bus.dready = 1;
    for (int i = 0; i < DEPTH; i++) ram_m[i] = 0;
    tick(); tick();
    check("rst_dout", bus.dout, 0);
    check("rst_dvalid", bus.dvalid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_ain_ready", bus.ain_ready, 0);
    areset = 1'b0;
    tick();
    check("post_rst_busy", bus.busy, 0);
    check("post_rst_ain_ready", bus.ain_ready, 0);
    // ramp B times all-ones A
    for (int i = 0; i < DEPTH; i++) wr(i, i + 1);
    a = '{default: 1};
    run_job(8, a, 0, 0);
    // extreme negatives: wraps to 0 or clamps to 32767
    for (int i = 0; i < DEPTH; i++) wr(i, -128);
    a = '{default: -128};
    run_job(8, a, 0, 0);
    // short job with bubbles between beats
    wr(0, 5); wr(1, -3); wr(2, 2);
    a = '{2, 4, -7, 0, 0, 0, 0, 0};
    run_job(3, a, 2, 0);
    // result held in DONE with dready low; start during the hold is ignored
    bus.dready = 1'b0;
    a = '{7, -9, 0, 0, 0, 0, 0, 0};
    run_job(2, a, 0, 0);
    for (int k = 0; k < 5; k++) begin
      check("hold_dvalid", bus.dvalid, 1);
      check("hold_dout", $signed(bus.dout), $signed(exp_q[0]));
      bus.start = (k == 2);
      bus.len = 4'd2;
      tick();
    end
    bus.start = 1'b0;
    bus.dready = 1'b1;
    tick();
    check("hold_release_busy", bus.busy, 0);
    check("hold_release_dvalid", bus.dvalid, 0);
    tick(); tick();
    check("start_in_done_ignored", bus.busy, 0);
    // reset in the middle of a job
    wr(0, 3);
    bus.start = 1'b1;
    bus.len = 4'd8;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 2; k++) begin bus.ain = 8'sd9; bus.ain_valid = 1'b1; tick(); end
    bus.ain_valid = 1'b0;
    areset = 1'b1;
    tick();
    areset = 1'b0;
    check("abort_busy", bus.busy, 0);
    check("abort_dvalid", bus.dvalid, 0);
    check("abort_ain_ready", bus.ain_ready, 0);
    a = '{4, 0, 0, 0, 0, 0, 0, 0};
    run_job(1, a, 0, 0);
    // len=0 start is ignored
    bus.start = 1'b1;
    bus.len = '0;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      check("len0_busy", bus.busy, 0);
      check("len0_dvalid", bus.dvalid, 0);
      tick();
    end
    // randomized jobs with bubbles and result back-pressure
    for (int j = 0; j < 25; j++) begin
      for (int i = 0; i < DEPTH; i++) wr(i, int'($urandom_range(255)) - 128);
      for (int i = 0; i < DEPTH; i++) a[i] = int'($urandom_range(255)) - 128;
      n = int'($urandom_range(1, DEPTH));
      bus.dready = ($urandom_range(2) != 0);
      run_job(n, a, 0, 25);
      if (!bus.dready) begin
        repeat ($urandom_range(1, 4)) tick();
        bus.dready = 1'b1;
        tick();
        check("rand_release_busy", bus.busy, 0);
      end
    end
    tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pe_mac_vec.md
Name: pe_mac_vec

Overview:
- Parametrised successor of the single-lane processing element.
- Computes a signed dot product between a streamed A vector and a B vector held in the PE's local RAM. Vector length is selectable per job.
- Uses an explicit start/run/drain/done FSM and ready/valid handshakes in place of the free-running load counter.
- Sits between the matrix-row broadcaster (A stream, RAM preload) and the result collector.

Parameters:
- DATA_W, 8, width of signed A and B elements.
- L_RAM_SIZE, 3, log2 of local RAM depth; depth = 2**L_RAM_SIZE.
- OUT_W, 16, width of the dout result.
- ACC_W, 2*DATA_W+L_RAM_SIZE, internal accumulator width; derived, do not override.

Ports:
- aclk, in, 1, clock.
- areset, in, 1, reset.
- din, in, DATA_W, RAM write data (B element).
- addr, in, L_RAM_SIZE, RAM write address.
- we, in, 1, RAM write enable.
- start, in, 1, job start pulse; sampled in IDLE only.
- len, in, L_RAM_SIZE+1, element count for the job, 1..2**L_RAM_SIZE; sampled with start.
- ain, in, DATA_W, A element.
- ain_valid, in, 1, A element valid.
- ain_ready, out, 1, PE accepts an A element this cycle.
- busy, out, 1, high in any state other than IDLE.
- dout, out, OUT_W, dot-product result.
- dvalid, out, 1, result valid.
- dready, in, 1, result consumer ready.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
  - areset=1 at a rising edge forces IDLE and clears the accumulator, pipeline valids, element counter, dout and dvalid to 0.
  - ain_ready and busy are 0 during and after reset.
  - RAM contents are not cleared.
  - Reset mid-job aborts the job with no result emitted.
- FSM states:
  - IDLE:
    - ain_ready=0.
    - start=1 latches len, clears the accumulator and idx, and moves to RUN.
    - len=0 with start is ignored and the FSM stays in IDLE.
  - RUN:
    - ain_ready=1.
    - Each accepted beat (ain_valid & ain_ready) reads peram[idx], registers ain and increments idx.
    - The beat where idx == len-1 moves to DRAIN.
    - Cycles without ain_valid insert bubbles; no timeout.
  - DRAIN:
    - ain_ready=0.
    - Waits until pipeline stages 1 and 2 are both empty (two cycles), then moves to DONE and asserts dvalid.
  - DONE:
    - dvalid=1; dout holds stable until dvalid & dready, then the FSM goes to IDLE.
    - start is ignored in DONE.
- Pipeline (per accepted beat):
  - Stage 1: registered ain plus synchronous RAM read.
  - Stage 2: registered signed product, 2*DATA_W bits.
  - Stage 3: sign-extended add into the ACC_W accumulator.
- Latency: dvalid rises exactly 3 cycles after the last accepted beat.
  - Minimum job time, len=L, back-to-back input: start at cycle 0, beats at cycles 1..L, dvalid at cycle L+3.
- RAM:
  - Single port, write-first not required.
  - A write (we=1) in the same cycle as an accepted beat has priority and that beat's read returns undefined data. Writes during RUN are therefore illegal, and the bench checks that they never occur.
  - Writes are legal in IDLE, DRAIN and DONE.
- Arithmetic:
  - All operands are signed two's complement.
  - ACC_W is sized so no internal overflow occurs for any len.
  - dout is derived from the accumulator per the SAT_EN option.
- dvalid is registered, and dout is registered when the FSM enters DONE.

Optional Feature:
- Macro: PE_MAC_VEC_SAT_EN.
- Defined: dout = accumulator clamped to the signed OUT_W range [-(2**(OUT_W-1)), 2**(OUT_W-1)-1].
- Undefined: dout = accumulator[OUT_W-1:0] (wrap/truncate).
- Latency is identical in both builds.

Decomposition:
- Package pe_pkg holds:
  - FSM state enum (S_IDLE, S_RUN, S_DRAIN, S_DONE).
  - ACC_W derivation function.
  - Saturation function sat_signed(acc, OUT_W).
- Sub-module pe_ram: single-port synchronous RAM with block RAM style, DATA_W x 2**L_RAM_SIZE. It is reused by future multi-lane PEs.

Test Plan:
- Default params, RAM = {1,2,3,4,5,6,7,8}, start len=8, A = all 1 back-to-back -> dvalid at cycle 11 after start, dout=36, ain_ready low from cycle 9.
- RAM = {-128 x8}, A = {-128 x8}, len=8 -> accumulator 131072. With SAT_EN: dout=32767. Without: dout=0 (131072 mod 2**16).
- len=3, RAM[0..2] = {5,-3,2}, A = {2,4,-7} with ain_valid bubbles between beats -> dout=-16, dvalid 3 cycles after third beat.
- dready held low for 5 cycles in DONE -> dout and dvalid stable; start pulsed during hold ignored; dready=1 -> IDLE next cycle.
- areset asserted during RUN after 2 beats -> next cycle IDLE, dvalid=0, busy=0. A new job len=1 (RAM[0]=3, A=4) then yields dout=12 with no residue.
- start with len=0 -> remains IDLE, busy=0, no dvalid for 10 cycles.
